// File: rtl/tmds_decoder_if.sv
// Symbol-side bundle of one TMDS receive channel: raw deserialized word in, decoded symbol and alignment status out.
interface tmds_decoder_if;
  localparam int unsigned RAW_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTRL_W = 2;
  localparam int unsigned OFF_W  = 4;

  logic [RAW_W-1:0]  raw_in;
  logic [DATA_W-1:0] data_out;
  logic [CTRL_W-1:0] control_out;
  logic              ve_out;
  logic              locked_out;
  logic [OFF_W-1:0]  offset_out;

  modport master (
    output raw_in,
    input  data_out, control_out, ve_out, locked_out, offset_out
  );

  modport slave (
    input  raw_in,
    output data_out, control_out, ve_out, locked_out, offset_out
  );
endinterface

// File: rtl/tmds_decoder.sv
// TMDS receive decoder: hunts for the symbol boundary using runs of control tokens,
// then decodes each aligned 10-bit symbol to 8-bit video data or a 2-bit control code.
module tmds_decoder #(
  parameter int unsigned LOCK_RUN  = 8,
  parameter int unsigned SLIP_WAIT = 4096
) (
  input logic           clk_in,
  input logic           rst_n_in,
  tmds_decoder_if.slave bus
);
  localparam int unsigned RAW_W    = 10;
  localparam int unsigned HIST_W   = 19;
  localparam int unsigned DATA_W   = 8;
  localparam int unsigned CTRL_W   = 2;
  localparam int unsigned OFF_W    = 4;
  localparam int unsigned RUN_W    = 8;
  localparam int unsigned TMR_W    = 16;
  localparam int unsigned OFF_CNT  = 10;

  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(LOCK_RUN);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(SLIP_WAIT - 1);
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(OFF_CNT - 1);

  localparam logic [RAW_W-1:0] TOK_00 = 10'b1101010100;
  localparam logic [RAW_W-1:0] TOK_01 = 10'b0010101011;
  localparam logic [RAW_W-1:0] TOK_10 = 10'b0101010100;
  localparam logic [RAW_W-1:0] TOK_11 = 10'b1010101011;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [RAW_W-1:0]    cur, prev, win;
  logic [HIST_W-1:0]   hist;
  logic [RUN_W-1:0]    run_cnt, run_nxt;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic [OFF_W-1:0]    offset, offset_nxt;
  logic                hit;
  logic [CTRL_W-1:0]   code;
  logic [DATA_W-1:0]   dmask, decoded;
  logic [DATA_W-1:0]   data_q, data_nxt;
  logic [CTRL_W-1:0]   ctrl_q, ctrl_nxt;
  logic                ve_q, ve_nxt;
  logic                locked_q, locked_nxt;

  // The top bit of cur never lands in any window (highest offset is 9), so it is left out.
  assign hist = {cur[RAW_W-2:0], prev};

  always_comb begin
    win = hist[RAW_W-1:0];
    for (int k = 1; k < int'(OFF_CNT); k++) begin
      if (offset == OFF_W'(k)) win = hist[k +: RAW_W];
    end
  end

  always_comb begin
    hit  = 1'b0;
    code = 2'b00;
    case (win)
      TOK_00:  begin hit = 1'b1; code = 2'b00; end
      TOK_01:  begin hit = 1'b1; code = 2'b01; end
      TOK_10:  begin hit = 1'b1; code = 2'b10; end
      TOK_11:  begin hit = 1'b1; code = 2'b11; end
      default: begin hit = 1'b0; code = 2'b00; end
    endcase
  end

  // Undo the optional inversion (bit 9), then the XOR/XNOR transition chain (bit 8).
  always_comb begin
    dmask      = win[9] ? ~win[DATA_W-1:0] : win[DATA_W-1:0];
    decoded    = '0;
    decoded[0] = dmask[0];
    for (int i = 1; i < int'(DATA_W); i++) begin
      decoded[i] = win[8] ? (dmask[i] ^ dmask[i-1]) : ~(dmask[i] ^ dmask[i-1]);
    end
  end

  // State register, alignment counters and history.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state   <= SEARCH;
      run_cnt <= '0;
      timer   <= '0;
      offset  <= '0;
      cur     <= '0;
      prev    <= '0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_nxt;
      timer   <= timer_nxt;
      offset  <= offset_nxt;
      cur     <= bus.raw_in;
      prev    <= cur;
    end
  end

  // A hit always clears the timer, so a token on the expiry cycle suppresses the slip.
  always_comb begin
    state_nxt  = state;
    run_nxt    = run_cnt;
    timer_nxt  = timer;
    offset_nxt = offset;
    if (hit) begin
      timer_nxt = '0;
      run_nxt   = (run_cnt >= RUN_MAX) ? RUN_MAX : run_cnt + RUN_W'(1);
      if (state == SEARCH && run_nxt == RUN_MAX) state_nxt = LOCKED;
    end else if (timer == TMR_MAX) begin
      offset_nxt = (offset == OFF_LAST) ? '0 : offset + OFF_W'(1);
      timer_nxt  = '0;
      run_nxt    = '0;
      state_nxt  = SEARCH;
    end else begin
      run_nxt   = '0;
      timer_nxt = timer + TMR_W'(1);
    end
  end

  always_comb begin
    data_nxt   = '0;
    ctrl_nxt   = '0;
    ve_nxt     = 1'b0;
    locked_nxt = (state == LOCKED);
    if (state == LOCKED) begin
      if (hit) begin
        ctrl_nxt = code;
      end else begin
        data_nxt = decoded;
        ctrl_nxt = ctrl_q;
        ve_nxt   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      data_q   <= '0;
      ctrl_q   <= '0;
      ve_q     <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      data_q   <= data_nxt;
      ctrl_q   <= ctrl_nxt;
      ve_q     <= ve_nxt;
      locked_q <= locked_nxt;
    end
  end

  assign bus.data_out    = data_q;
  assign bus.control_out = ctrl_q;
  assign bus.ve_out      = ve_q;
  assign bus.locked_out  = locked_q;
  assign bus.offset_out  = offset;
endmodule

// File: doc/tmds_decoder.md
# tmds_decoder

Receive-side TMDS symbol decoder for the HDMI/DVI input path. It takes 10-bit words from an upstream 1:10 deserializer whose word boundary is unknown, and finds the correct bit offset by hunting for runs of control tokens. It then decodes each aligned symbol back to 8-bit video data or a 2-bit control code. One instance serves one channel (R, G or B), and it is the inverse of the transmit-side TMDS encoder.

## Interface
Parameters:
- LOCK_RUN, default 8: consecutive control tokens at the current offset required to declare lock (range 2..255).
- SLIP_WAIT, default 4096: cycles without a control token at the current offset before slipping one bit (range 16..65535; must exceed one video line).

Ports:
- clk_in  input  1  pixel clock; all logic on its rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- raw_in  input  10  deserialized word; raw_in[0] is the earliest-received bit.
- data_out  output  8  decoded video data.
- control_out  output  2  decoded control code.
- ve_out  output  1  1 = data_out is valid video; 0 = control period.
- locked_out  output  1  alignment lock indicator.
- offset_out  output  4  current bit offset, 0..9.

## Operation
**History and window**
- Each cycle the block registers `cur <= raw_in` and `prev <= cur`.
- History is H = {cur, prev}, 20 bits, with prev in H[9:0].
- The window at offset k is H[k+9:k].
- Slipping changes only k. History is never flushed.

**Token classification (window w)**
- 10'b1101010100 gives control 00.
- 10'b0010101011 gives control 01.
- 10'b0101010100 gives control 10.
- 10'b1010101011 gives control 11.
- Any other value is a data symbol.

**Data decode**
- d = w[9] ? ~w[7:0] : w[7:0].
- q[0] = d[0].
- For i = 1..7: q[i] = w[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).

**State machine**
- States: SEARCH (reset state) and LOCKED.
- run_cnt is 8 bits; timer is 16 bits.
- Control-token hit at the current offset: timer clears, and run_cnt increments, saturating at LOCK_RUN.
- In SEARCH, when run_cnt reaches LOCK_RUN, the state moves to LOCKED.
- Any non-token symbol clears run_cnt and increments the timer.
- Timer reaches SLIP_WAIT-1 and the current symbol is a non-token:
  - offset increments modulo 10 (9 wraps to 0);
  - timer and run_cnt clear;
  - state moves to SEARCH (from either state).
- A hit on the same cycle the timer would expire wins: no slip occurs.
- In LOCKED, a miss never causes a slip by itself; only timer expiry does.

**Output register (updated every edge)**
- State LOCKED at the edge:
  - load decoded data_out / control_out;
  - ve_out = 1 for a data symbol, 0 for a control token;
  - data_out = 0 on control tokens;
  - control_out holds its last value during data.
- Otherwise: data_out, control_out and ve_out load 0.
- locked_out <= (state == LOCKED).
- offset_out reflects the offset register directly.

## Timing
- Reset (asynchronous, rst_n_in low): every output is 0, offset 0, state SEARCH, counters 0, history 0.
- Reset asserted mid-lock takes effect immediately, with no clock needed.
- Latency: a symbol whose offset-0 bits arrive on raw_in at edge t appears on the outputs after edge t+2. The latency is identical for every offset k; bits above k come from the following word.
- Lock timing: the LOCK_RUN-th consecutive hit is evaluated at edge e, the state becomes LOCKED at e. locked_out and the first decoded output appear at edge e+1.
- Loss timing: locked_out falls one edge after the slip edge, and outputs zero from that same edge.
- The block has no backpressure; it accepts one word every cycle.

## Test plan
- **Reset:** assert rst_n_in with a clock running, then deassert -> all outputs 0, offset_out 0, locked_out 0 until LOCK_RUN tokens are seen.
- **Aligned lock (LOCK_RUN=4):** drive 10'b1101010100 continuously -> locked_out rises one edge after the 4th token is evaluated, with control_out 00 and ve_out 0. Then drive 10'b0010101011 -> control_out 01 after 3 edges.
- **Round-trip:**
  - After lock, drive all 256 values through the encoder model with disparity tracking -> data_out equals the source, ve_out 1, latency 3.
  - 10'b0100000000 -> 0x00.
- **Misaligned stream (offset 3, SLIP_WAIT=16):** bits rotated by 3 -> offset_out steps 0,1,2,3 and locks at 3. Decoded data then matches the source.
- **Loss and wrap:**
  - After lock, send SLIP_WAIT data symbols with no tokens -> locked_out falls and offset_out increments.
  - From offset 9 -> wraps to 0.
  - A token sent exactly on the expiry cycle -> no slip.
- **Mid-lock reset:** pulse rst_n_in low between clock edges while locked -> outputs clear immediately, and relock follows the normal sequence.
